mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Single-outstanding load/store unit sitting between a core and a simple
//   64-bit memory. One request is accepted in IDLE, checked for alignment,
//   then issued as exactly one read or one write cycle before the response
//   is held until the core takes it.
//
// Ports
//   clock, reset                 : clock, asynchronous active-high reset
//   req_valid / req_ready        : request handshake (ready only in IDLE)
//   req_wen, req_addr, req_wdata : store flag, byte address, store data (low bytes)
//   req_size, req_signed         : log2 access bytes, sign-extend loads
//   resp_valid / resp_ready      : response handshake
//   resp_rdata, resp_misalign    : load result (0 for stores), misalignment flag
//   memRead_*                    : 8-byte aligned read port, data is combinational
//   memWrite_*                   : byte-addressed write port with byte count
module mem_access_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic [63:0] memRead_addr,
  output logic        memRead_en,
  input  logic [63:0] memRead_data,
  output logic [63:0] memWrite_addr,
  output logic [63:0] memWrite_data,
  output logic        memWrite_en,
  output logic [3:0]  memWrite_wrSize
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state, next_state;

  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        wen_q;
  logic [63:0] rdata_q;
  logic        misalign_q;

  logic        accept;
  logic        req_misaligned;
  logic [63:0] shifted;
  logic [63:0] load_result;
  logic [63:0] store_data;
  logic [3:0]  size_bytes;

  assign accept = req_valid && req_ready;

  // Misaligned when any address bit below the access size is set.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'd0: req_misaligned = 1'b0;
      2'd1: req_misaligned = req_addr[0];
      2'd2: req_misaligned = |req_addr[1:0];
      2'd3: req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // Bring the addressed bytes of the 8-byte word down to bit 0, then
  // truncate and extend according to the registered size and sign flag.
  always_comb begin
    shifted     = memRead_data >> {addr_q[2:0], 3'b000};
    load_result = 64'd0;
    case (size_q)
      2'd0: load_result = signed_q ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      2'd1: load_result = signed_q ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      2'd2: load_result = signed_q ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      2'd3: load_result = shifted;
      default: load_result = shifted;
    endcase
  end

  // Store data keeps only the bytes covered by the access; size as a byte count.
  always_comb begin
    store_data = 64'd0;
    size_bytes = 4'd0;
    case (size_q)
      2'd0: begin store_data = {56'd0, wdata_q[7:0]};  size_bytes = 4'd1; end
      2'd1: begin store_data = {48'd0, wdata_q[15:0]}; size_bytes = 4'd2; end
      2'd2: begin store_data = {32'd0, wdata_q[31:0]}; size_bytes = 4'd4; end
      2'd3: begin store_data = wdata_q;                size_bytes = 4'd8; end
      default: begin store_data = wdata_q;             size_bytes = 4'd8; end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: misaligned requests skip memory entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_misaligned) next_state = RESP;
          else if (req_wen)   next_state = WRITE;
          else                next_state = READ;
        end
      end
      READ:    next_state = RESP;
      WRITE:   next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture at accept, load data capture at the end of READ.
  // rdata is cleared at accept so stores and misaligned accesses return 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      wen_q      <= 1'b0;
      rdata_q    <= 64'd0;
      misalign_q <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        signed_q   <= req_signed;
        wen_q      <= req_wen;
        rdata_q    <= 64'd0;
        misalign_q <= req_misaligned;
      end else if (state == READ && !wen_q) begin
        rdata_q <= load_result;
      end
    end
  end

  // Outputs decode from state, so an async reset drops them immediately.
  always_comb begin
    req_ready       = (state == IDLE) && !reset;
    resp_valid      = (state == RESP);
    resp_rdata      = resp_valid ? rdata_q : 64'd0;
    resp_misalign   = resp_valid ? misalign_q : 1'b0;
    memRead_en      = (state == READ);
    memRead_addr    = memRead_en ? {addr_q[63:3], 3'b000} : 64'd0;
    memWrite_en     = (state == WRITE);
    memWrite_addr   = memWrite_en ? addr_q : 64'd0;
    memWrite_data   = memWrite_en ? store_data : 64'd0;
    memWrite_wrSize = memWrite_en ? size_bytes : 4'd0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: a table of loads and stores with
// hand-computed memory-port and response values, a back-pressure case and a
// reset in the middle of a read.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic [63:0] memRead_addr;
  logic        memRead_en;
  logic [63:0] memRead_data;
  logic [63:0] memWrite_addr;
  logic [63:0] memWrite_data;
  logic        memWrite_en;
  logic [3:0]  memWrite_wrSize;

  int checkCount;
  int errorCount;

  mem_access_unit dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_wen         (req_wen),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_misalign   (resp_misalign),
    .memRead_addr    (memRead_addr),
    .memRead_en      (memRead_en),
    .memRead_data    (memRead_data),
    .memWrite_addr   (memWrite_addr),
    .memWrite_data   (memWrite_data),
    .memWrite_en     (memWrite_en),
    .memWrite_wrSize (memWrite_wrSize)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count a comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One complete transaction: handshake at the edge after the first negedge,
  // memory cycle checked in N+1, response held for 'hold' extra cycles.
  task automatic applyStimulus(
    input logic        wen,
    input logic [63:0] addr,
    input logic [63:0] wdata,
    input logic [1:0]  size,
    input logic        sgn,
    input logic [63:0] memWord,
    input logic [63:0] expRdata,
    input logic        expMis,
    input logic [63:0] expMemAddr,
    input logic [63:0] expMemData,
    input logic [3:0]  expWrSize,
    input int          hold
  );
    @(negedge clock);
    memRead_data = memWord;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_signed   = sgn;
    req_valid    = 1'b1;
    checkOutput("req_ready_idle", {63'd0, req_ready}, 64'd1);

    @(negedge clock);
    req_valid  = 1'b0;
    req_wen    = ~wen;
    req_addr   = ~addr;
    req_wdata  = ~wdata;
    req_size   = ~size;
    req_signed = ~sgn;
    if (expMis) begin
      checkOutput("mis_resp_valid_n1", {63'd0, resp_valid}, 64'd1);
      checkOutput("mis_no_read_en", {63'd0, memRead_en}, 64'd0);
      checkOutput("mis_no_write_en", {63'd0, memWrite_en}, 64'd0);
    end else begin
      checkOutput("resp_valid_n1", {63'd0, resp_valid}, 64'd0);
      if (wen) begin
        checkOutput("write_en", {63'd0, memWrite_en}, 64'd1);
        checkOutput("write_no_read_en", {63'd0, memRead_en}, 64'd0);
        checkOutput("write_addr", memWrite_addr, expMemAddr);
        checkOutput("write_data", memWrite_data, expMemData);
        checkOutput("write_size", {60'd0, memWrite_wrSize}, {60'd0, expWrSize});
      end else begin
        checkOutput("read_en", {63'd0, memRead_en}, 64'd1);
        checkOutput("read_no_write_en", {63'd0, memWrite_en}, 64'd0);
        checkOutput("read_addr", memRead_addr, expMemAddr);
      end
      @(negedge clock);
    end

    for (int i = 0; i <= hold; i++) begin
      memRead_data = ~memWord;
      checkOutput("resp_valid", {63'd0, resp_valid}, 64'd1);
      checkOutput("resp_rdata", resp_rdata, expRdata);
      checkOutput("resp_misalign", {63'd0, resp_misalign}, {63'd0, expMis});
      checkOutput("resp_req_ready", {63'd0, req_ready}, 64'd0);
      checkOutput("resp_enables", {62'd0, memRead_en, memWrite_en}, 64'd0);
      checkOutput("resp_mem_outputs_zero", memRead_addr | memWrite_addr | memWrite_data | {60'd0, memWrite_wrSize}, 64'd0);
      if (i < hold) @(negedge clock);
    end

    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    checkOutput("after_resp_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("after_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_wen      = 1'b0;
    req_addr     = 64'd0;
    req_wdata    = 64'd0;
    req_size     = 2'd0;
    req_signed   = 1'b0;
    resp_ready   = 1'b0;
    memRead_data = 64'd0;

    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd0);
    checkOutput("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("rst_enables", {62'd0, memRead_en, memWrite_en}, 64'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", {63'd0, req_ready}, 64'd1);

    //            wen   addr                   wdata                  sz    sgn   memWord                exp rdata              mis   mem addr/data                               wrSz  hold
    applyStimulus(1'b0, 64'h0000_0000_8000_0008, 64'd0,                2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1'b0, 64'h0000_0000_8000_0008, 64'd0,                 4'd0, 0);
    applyStimulus(1'b0, 64'h0000_0000_8000_0003, 64'd0,                2'd0, 1'b1, 64'h0000_0000_F000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                 4'd0, 0);
    applyStimulus(1'b0, 64'h0000_0000_8000_0003, 64'd0,                2'd0, 1'b0, 64'h0000_0000_F000_0000, 64'h0000_0000_0000_00F0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                 4'd0, 0);
    applyStimulus(1'b1, 64'h0000_0000_8000_0102, 64'hDEAD_BEEF_CAFE_1234, 2'd1, 1'b0, 64'd0,                 64'd0,                 1'b0, 64'h0000_0000_8000_0102, 64'h0000_0000_0000_1234, 4'd2, 0);
    applyStimulus(1'b0, 64'h0000_0000_8000_0006, 64'd0,                2'd2, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0,                 1'b1, 64'd0,                 64'd0,                 4'd0, 0);
    applyStimulus(1'b0, 64'h0000_0000_8000_0006, 64'd0,                2'd1, 1'b1, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                 4'd0, 0);
    applyStimulus(1'b0, 64'h0000_0000_8000_0004, 64'd0,                2'd2, 1'b0, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                 4'd0, 0);
    applyStimulus(1'b0, 64'h0000_0000_8000_0004, 64'd0,                2'd2, 1'b1, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 64'h0000_0000_8000_0000, 64'd0,                 4'd0, 0);
    applyStimulus(1'b1, 64'h0000_0000_8000_0005, 64'h1122_3344_5566_7788, 2'd0, 1'b0, 64'd0,                 64'd0,                 1'b0, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_0088, 4'd1, 0);
    applyStimulus(1'b1, 64'h0000_0000_8000_000C, 64'hCAFE_BABE_1234_5678, 2'd2, 1'b0, 64'd0,                 64'd0,                 1'b0, 64'h0000_0000_8000_000C, 64'h0000_0000_1234_5678, 4'd4, 0);
    applyStimulus(1'b1, 64'h0000_0000_8000_0004, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b0, 64'd0,                 64'd0,                 1'b1, 64'd0,                 64'd0,                 4'd0, 0);
    applyStimulus(1'b1, 64'h0000_0000_8000_0010, 64'h0102_0304_0506_0708, 2'd3, 1'b0, 64'd0,                 64'd0,                 1'b0, 64'h0000_0000_8000_0010, 64'h0102_0304_0506_0708, 4'd8, 0);
    // Back-pressure: response held for five extra cycles.
    applyStimulus(1'b0, 64'h0000_0000_8000_0020, 64'd0,                2'd3, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'h0000_0000_8000_0020, 64'd0,                 4'd0, 5);

    // Reset asserted while the read is on the bus.
    @(negedge clock);
    memRead_data = 64'h1122_3344_5566_7788;
    req_wen      = 1'b0;
    req_addr     = 64'h0000_0000_8000_0040;
    req_size     = 2'd3;
    req_signed   = 1'b0;
    req_valid    = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    checkOutput("rstmid_read_en_before", {63'd0, memRead_en}, 64'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rstmid_read_en_dropped", {63'd0, memRead_en}, 64'd0);
    checkOutput("rstmid_read_addr_zero", memRead_addr, 64'd0);
    checkOutput("rstmid_req_ready_low", {63'd0, req_ready}, 64'd0);
    @(negedge clock);
    checkOutput("rstmid_no_resp", {63'd0, resp_valid}, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rstmid_release_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clock);
    checkOutput("rstmid_still_no_resp", {63'd0, resp_valid}, 64'd0);
    checkOutput("rstmid_still_idle", {63'd0, req_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
